// File: rtl/div_pkg.sv
// Shared widths and FSM state encoding for the sequential restoring divider.
package div_pkg;
  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  typedef logic [1:0] state_t;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/seq_div_if.sv
// Request/result bundle for seq_div, with the FSM state exported for debug.
interface seq_div_if
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) ();
  // Handshake: start is a request taken on a rising edge whenever busy is low
  // (IDLE or DONE); operands must be valid in that same cycle. done pulses for
  // one cycle with results valid; results hold until the next accepted request.
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  state_t                state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, state
  );
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, state
  );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, compare, conditionally subtract.
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W:0]   i_rem,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W:0]   o_rem,
  output logic                 o_qbit
);
  logic [DIVISOR_W:0] w_shift;
  logic               w_ge;

  // The partial remainder stays below the divisor, so its top bit is never set;
  // folding it into the compare keeps the step safe if it ever were.
  assign w_shift = {i_rem[DIVISOR_W-1:0], i_bit};
  assign w_ge    = i_rem[DIVISOR_W] | (w_shift >= {1'b0, i_divisor});
  assign o_rem   = w_ge ? (w_shift - {1'b0, i_divisor}) : w_shift;
  assign o_qbit  = w_ge;
endmodule

// File: rtl/seq_div.sv
// Sequential unsigned restoring divider: one quotient bit per CALC cycle.
module seq_div
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_div_if.slave  bus
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  state_t                r_state;
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVIDEND_W-1:0] r_qwork;
  logic [DIVIDEND_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0]  r_dvs;
  logic [DIVISOR_W-1:0]  r_remainder;
  logic [DIVISOR_W:0]    r_prem;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_dbz;

  logic [DIVISOR_W:0]    w_next_rem;
  logic                  w_qbit;
  logic                  w_accept;
  logic                  w_last;

  assign w_accept = bus.start && (r_state != S_CALC);
  assign w_last   = (r_cnt == CNT_W'(1));

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .i_rem     (r_prem),
    .i_bit     (r_dvd[DIVIDEND_W-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_next_rem),
    .o_qbit    (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dvd       <= '0;
      r_qwork     <= '0;
      r_quotient  <= '0;
      r_dvs       <= '0;
      r_remainder <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_CALC: begin
          r_prem  <= w_next_rem;
          r_dvd   <= {r_dvd[DIVIDEND_W-2:0], 1'b0};
          r_qwork <= {r_qwork[DIVIDEND_W-2:0], w_qbit};
          r_cnt   <= r_cnt - CNT_W'(1);
          // Visible results only move here, on the way into DONE.
          if (w_last) begin
            r_state     <= S_DONE;
            r_quotient  <= {r_qwork[DIVIDEND_W-2:0], w_qbit};
            r_remainder <= w_next_rem[DIVISOR_W-1:0];
          end
        end
        default: begin
          if (w_accept) begin
            if (bus.divisor == '0) begin
              r_state     <= S_DONE;
              r_quotient  <= '1;
              r_remainder <= '1;
              r_dbz       <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_dvd   <= bus.dividend;
              r_dvs   <= bus.divisor;
              r_prem  <= '0;
              r_qwork <= '0;
              r_cnt   <= CNT_W'(DIVIDEND_W);
              r_dbz   <= 1'b0;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy        = (r_state == S_CALC);
  assign bus.done        = (r_state == S_DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;
  assign bus.state       = r_state;
endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 The block SHALL have parameter DIVIDEND_W, default 8, dividend and quotient width.
REQ-002 The block SHALL have parameter DIVISOR_W, default 4, divisor and remainder width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request pulse; operands are sampled on the accepting edge.
REQ-006 dividend  input  DIVIDEND_W  numerator, unsigned; the product-width operand.
REQ-007 divisor  input  DIVISOR_W  denominator, unsigned.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; results are valid from this cycle.
REQ-010 quotient  output  DIVIDEND_W  unsigned quotient.
REQ-011 remainder  output  DIVISOR_W  unsigned remainder.
REQ-012 div_by_zero  output  1  set when the accepted divisor is 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 start SHALL be accepted only in IDLE or DONE; start in CALC SHALL be ignored with no effect.
REQ-015 On accept with divisor != 0: operands are latched, the step counter is loaded with DIVIDEND_W, the partial remainder is cleared, div_by_zero is cleared, and the FSM goes to CALC.
REQ-016 Each CALC cycle SHALL do one restoring step: shift the next dividend MSB into the partial remainder; if partial remainder >= divisor, subtract and shift in quotient bit 1, else shift in 0.
REQ-017 The partial remainder SHALL be DIVISOR_W+1 bits wide internally so the compare never overflows.
REQ-018 After DIVIDEND_W CALC cycles the FSM SHALL enter DONE.
REQ-019 Accept-to-done latency SHALL be exactly DIVIDEND_W+1 cycles (9 at default).
REQ-020 busy SHALL be high in every CALC cycle and low in IDLE and DONE.
REQ-021 done SHALL be high for exactly the single cycle spent in DONE.
REQ-022 DONE SHALL return to IDLE unless start is high, in which case a new operation is accepted (back-to-back).
REQ-023 On accept with divisor == 0: CALC is skipped and DONE follows on the next cycle with quotient = all ones, remainder = all ones, div_by_zero = 1.
REQ-024 quotient, remainder and div_by_zero SHALL hold their last values until the next accept.
REQ-025 quotient and remainder SHALL NOT change during CALC; results are committed on the transition into DONE.
REQ-026 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every divisor != 0.

Reset
REQ-027 Asserting rst_n low SHALL immediately force IDLE and zero busy, done, quotient, remainder, div_by_zero and all internal registers.
REQ-028 Reset asserted mid-CALC SHALL abandon the operation; no done pulse SHALL follow its release.
REQ-029 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package (div_pkg) SHALL hold the default width constants and the state enumeration.
REQ-031 The one-bit restoring step (shift, compare, conditional subtract) SHALL be a combinational sub-module div_step instanced once in seq_div.
REQ-032 The block SHALL contain no multi-cycle combinational paths.

Verification
REQ-033 A bench SHALL drive dividend=6, divisor=3 -> done 9 cycles later with quotient=2, remainder=0, div_by_zero=0.
REQ-034 A bench SHALL drive dividend=20/divisor=5 and then 42/7 back-to-back, with start high during done -> quotient 4 r0, then 6 r0; the second done SHALL come 9 cycles after the first.
REQ-035 A bench SHALL drive dividend=100, divisor=7 -> quotient=14, remainder=2; and dividend=255, divisor=1 -> quotient=255, remainder=0.
REQ-036 A bench SHALL drive dividend=37, divisor=0 -> done after 1 cycle with quotient=0xFF, remainder=0xF, div_by_zero=1; a following 9/4 SHALL clear div_by_zero and return quotient 2 r1.
REQ-037 A bench SHALL pulse start with 13/2 during cycle 3 of a 50/6 operation -> the second start is ignored and the result is quotient 8, remainder 2.
REQ-038 A bench SHALL assert rst_n low in cycle 4 of a 200/9 operation, then run 6/3 after release -> all outputs are 0 during reset, no stale done appears, and the result is quotient 2, remainder 0.
